// File: rtl/cfg_bank_prog_ctrl.sv
// cfg_bank_prog_ctrl
// Programs one tile's configuration bank one row at a time. Config words
// arrive on a valid/ready stream and are packed into a bitline row image.
// The matching wordline is then strobed with setup/pulse/hold timing. After
// the last row a one-cycle done pulse is emitted.
// Optional feature macro: CFG_PARITY_EN (per-word even-parity check, sticky
// err flag, and suppression of the wordline pulse for a corrupted row).
module cfg_bank_prog_ctrl #(
  parameter int BL_W      = 315,
  parameter int WL_N      = 4,
  parameter int DATA_W    = 16,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  localparam int RW       = (WL_N > 1) ? $clog2(WL_N) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_par,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [BL_W-1:0]   bl_out,
  output logic [WL_N-1:0]   wl_out,
  output logic [RW-1:0]     row_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Words needed to fill one row, and the packing register width
  localparam int WPR  = (BL_W + DATA_W - 1) / DATA_W;
  localparam int SH_W = WPR * DATA_W;
  localparam int WCW  = (WPR > 1) ? $clog2(WPR) : 1;

  // One shared phase counter serves SETUP, PULSE and HOLD
  localparam int TMAX = (SETUP_CYC > PULSE_CYC)
                        ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                        : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [WCW-1:0] WC_LAST    = WCW'(WPR - 1);
  localparam logic [TW-1:0]  SETUP_LAST = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0]  PULSE_LAST = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0]  HOLD_LAST  = TW'(HOLD_CYC - 1);
  localparam logic [RW-1:0]  ROW_LAST   = RW'(WL_N - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic [WL_N-1:0]   wl_q, wl_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Event strobes shared with the optional parity logic
  logic              start_take;
  logic              row_open;
  logic              take;
  logic              wl_block;

  // Sequencer: state, row/word/phase counters and the row packing register
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    wcnt_d     = wcnt_q;
    tcnt_d     = tcnt_q;
    sh_d       = sh_q;
    start_take = 1'b0;
    row_open   = 1'b0;
    take       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d    = ST_LOAD;
          row_d      = '0;
          wcnt_d     = '0;
          start_take = 1'b1;
          row_open   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (cfg_valid && cfg_ready_q) begin
          take = 1'b1;
          sh_d = {cfg_data, sh_q[SH_W-1:DATA_W]};
          if (wcnt_q == WC_LAST) begin
            state_d = ST_SETUP;
            tcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + WCW'(1);
          end
        end
      end
      ST_SETUP: begin
        if (tcnt_q == SETUP_LAST) begin
          state_d = ST_PULSE;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_PULSE: begin
        if (tcnt_q == PULSE_LAST) begin
          state_d = ST_HOLD;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_HOLD: begin
        if (tcnt_q == HOLD_LAST) begin
          if (row_q == ROW_LAST) begin
            state_d = ST_DONE;
            row_d   = '0;
          end else begin
            state_d  = ST_LOAD;
            row_d    = row_q + RW'(1);
            wcnt_d   = '0;
            row_open = 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        row_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        row_d   = '0;
      end
    endcase

    // Abort cancels whatever is in flight but leaves the bitline image alone
    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      row_d    = '0;
      sh_d     = sh_q;
      take     = 1'b0;
      row_open = 1'b0;
    end
  end

  // Registered outputs derived from the upcoming state so they align with it
  always_comb begin
    cfg_ready_d = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    wl_d        = '0;
    if ((state_d == ST_PULSE) && !wl_block) begin
      for (int i = 0; i < WL_N; i++) begin
        wl_d[i] = (row_d == RW'(i));
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
      sh_q        <= '0;
      cfg_ready_q <= 1'b0;
      wl_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      wcnt_q      <= wcnt_d;
      tcnt_q      <= tcnt_d;
      sh_q        <= sh_d;
      cfg_ready_q <= cfg_ready_d;
      wl_q        <= wl_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef CFG_PARITY_EN
  logic err_q, err_d;
  logic row_bad_q, row_bad_d;

  // Sticky error plus a per-row flag that vetoes the wordline pulse
  always_comb begin
    err_d     = err_q;
    row_bad_d = row_bad_q;
    if (start_take) begin
      err_d     = 1'b0;
      row_bad_d = 1'b0;
    end else if (row_open) begin
      row_bad_d = 1'b0;
    end else if (take && (^{cfg_data, cfg_par})) begin
      err_d     = 1'b1;
      row_bad_d = 1'b1;
    end
  end

  // Parity flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q     <= 1'b0;
      row_bad_q <= 1'b0;
    end else begin
      err_q     <= err_d;
      row_bad_q <= row_bad_d;
    end
  end

  assign wl_block = row_bad_d;
  assign err      = err_q;
`else
  logic unused_par;
  assign unused_par = ^{cfg_par, start_take, row_open, take};
  assign wl_block   = 1'b0;
  assign err        = 1'b0;
`endif

  // Packing bits above BL_W exist only to keep the shift word-aligned
  if (SH_W > BL_W) begin : g_sh_top
    logic unused_sh_top;
    assign unused_sh_top = ^sh_q[SH_W-1:BL_W];
  end

  assign cfg_ready = cfg_ready_q;
  assign bl_out    = sh_q[BL_W-1:0];
  assign wl_out    = wl_q;
  assign row_idx   = row_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cfg_bank_prog_ctrl.sv
// tb_cfg_bank_prog_ctrl
// Directed bench for cfg_bank_prog_ctrl at default parameters. Expected
// values come from a cycle timeline of a 24-cycle row (20 load, 1 setup,
// 2 pulse, 1 hold) and a row-image builder for the word pattern k = k.
module tb_cfg_bank_prog_ctrl;

  localparam int BL_W     = 315;
  localparam int WL_N     = 4;
  localparam int DATA_W   = 16;
  localparam int WPR      = 20;
  localparam int ROW_CYC  = 24;
  localparam int PROG_CYC = 96;

`ifdef CFG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_par;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [BL_W-1:0]   bl_out;
  logic [WL_N-1:0]   wl_out;
  logic [1:0]        row_idx;
  logic              busy;
  logic              done;
  logic              err;

  int checks   = 0;
  int failures = 0;
  int cur_n    = 0;

  cfg_bank_prog_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .cfg_data  (cfg_data),
    .cfg_par   (cfg_par),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .bl_out    (bl_out),
    .wl_out    (wl_out),
    .row_idx   (row_idx),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [319:0] actual,
                             input logic [319:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s (n=%0d): got 0x%0h, expected 0x%0h",
               tag, cur_n, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, cross one rising edge, settle before sampling
  task automatic applyStimulus(input logic s, input logic a, input logic v,
                               input logic [DATA_W-1:0] d, input logic p);
    start     = s;
    abort     = a;
    cfg_valid = v;
    cfg_data  = d;
    cfg_par   = p;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BL_W-1:0] rowImage(input int r);
    logic [319:0] img;
    img = '0;
    for (int w = 0; w < WPR; w++) img[16*w +: 16] = 16'(r * WPR + w);
    return img[BL_W-1:0];
  endfunction

  // Full programming run checked cycle by cycle against the nominal timeline
  task automatic runProgram(input int stall_at, input int stall_len,
                            input int bad_word, input int busy_start_at,
                            input int abort_at);
    int k, m, row, phase, last_n, bad_row, err_edge;
    logic v, s, a, p, err_exp;
    logic [3:0] wl_exp;
    logic [DATA_W-1:0] d;
    k        = 0;
    err_exp  = 1'b0;
    bad_row  = (PAR_EN && bad_word >= 0) ? bad_word / WPR : -1;
    err_edge = (bad_word >= 0) ? (bad_word / WPR) * ROW_CYC + 1 + bad_word % WPR
                               : 1 << 30;
    last_n   = (abort_at >= 0) ? abort_at + 3 : PROG_CYC + stall_len + 2;
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int n = 0; n <= last_n; n++) begin
      cur_n = n;
      if (stall_at < 0 || n <= stall_at) m = n;
      else if (n <= stall_at + stall_len) m = stall_at;
      else m = n - stall_len;

      if (abort_at >= 0 && n > abort_at) begin
        checkOutput("abort_wl", wl_out, 0);
        checkOutput("abort_ready", cfg_ready, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_row", row_idx, 0);
        if (n == abort_at + 1)
          checkOutput("abort_bl_kept", bl_out, rowImage(abort_at / ROW_CYC));
      end else begin
        err_exp = PAR_EN && (m >= err_edge);
        if (m < PROG_CYC) begin
          row    = m / ROW_CYC;
          phase  = m % ROW_CYC;
          wl_exp = ((phase == 21 || phase == 22) && row != bad_row)
                   ? (4'b0001 << row) : 4'b0000;
          checkOutput("ready", cfg_ready, phase < WPR);
          checkOutput("wl", wl_out, wl_exp);
          checkOutput("done", done, 0);
          checkOutput("busy", busy, 1);
          checkOutput("row_idx", row_idx, row);
          if (phase >= WPR) checkOutput("bl_row", bl_out, rowImage(row));
          if (m == WPR) begin
            checkOutput("bl_lo16", bl_out[15:0], 16'h0000);
            checkOutput("bl_top11", bl_out[314:304], 11'd19);
          end
        end else if (m == PROG_CYC) begin
          checkOutput("done_pulse", done, 1);
          checkOutput("done_wl", wl_out, 0);
          checkOutput("done_ready", cfg_ready, 0);
        end else begin
          checkOutput("idle_done", done, 0);
          checkOutput("idle_busy", busy, 0);
          checkOutput("idle_wl", wl_out, 0);
          checkOutput("idle_row", row_idx, 0);
        end
      end
      checkOutput("err", err, err_exp);

      v = !(stall_at >= 0 && n >= stall_at && n < stall_at + stall_len)
          && !(abort_at >= 0 && n >= abort_at);
      s = (n == busy_start_at) || (busy_start_at >= 0 && m == PROG_CYC);
      a = (n == abort_at);
      d = 16'(k);
      p = (^d) ^ (k == bad_word);
      if (cfg_ready && v && !a) k++;
      applyStimulus(s, a, v, d, p);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("rst_wl", wl_out, 0);
    checkOutput("rst_bl", bl_out, 0);
    checkOutput("rst_ready", cfg_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);

    $display("[TB] reset in the middle of a row-0 pulse");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i <= 20; i++) begin
      w = 16'(i);
      applyStimulus(1'b0, 1'b0, 1'b1, w, ^w);
    end
    checkOutput("pre_rst_wl", wl_out, 4'b0001);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("midrst_wl", wl_out, 0);
    checkOutput("midrst_bl", bl_out, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ready", cfg_ready, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("midrst2_wl", wl_out, 0);
    checkOutput("midrst2_busy", busy, 0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);

    $display("[TB] full program, back-to-back words");
    runProgram(-1, 0, -1, -1, -1);

    $display("[TB] five-cycle stall in row 1");
    runProgram(30, 5, -1, -1, -1);

    $display("[TB] bad parity on word 3 of row 1");
    runProgram(-1, 0, 23, -1, -1);

    $display("[TB] start with abort in IDLE, then start while busy");
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("st_ab_busy", busy, 0);
    checkOutput("st_ab_ready", cfg_ready, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("st_ab_busy2", busy, 0);
    runProgram(-1, 0, -1, 40, -1);

    $display("[TB] abort during row-2 pulse, then restart");
    runProgram(-1, 0, 23, -1, 69);
    runProgram(-1, 0, -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
